// File: rtl/fib_sched_pkg.sv
// fib_sched_pkg: channel state encoding and default parameter values
// shared by the Fibonacci scheduler, its arbiter and its bus interface.
package fib_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_LIMIT = 100;
    localparam int DEF_SEED  = 1;

endpackage

// File: rtl/fib_sched_if.sv
// fib_sched_if: per-channel start/clear requests and the status/result
// signals of the two-channel Fibonacci scheduler. The requester side uses
// the master modport, the scheduler uses the slave modport.
interface fib_sched_if #(
    parameter int W = 8
);
    logic         start0;
    logic         start1;
    logic         clr0;
    logic         clr1;
    logic         busy0;
    logic         busy1;
    logic         done0;
    logic         done1;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [1:0]   grant;
    logic         ovf;

    modport master (
        output start0, start1, clr0, clr1,
        input  busy0, busy1, done0, done1, x0, x1, grant, ovf
    );

    modport slave (
        input  start0, start1, clr0, clr1,
        output busy0, busy1, done0, done1, x0, x1, grant, ovf
    );
endinterface

// File: rtl/fib_rr_arb.sv
// fib_rr_arb: two-request arbiter for the shared adder. Grant is one-hot or
// zero and only ever goes to a requesting channel. Default build is
// round-robin with a pointer that moves to the other channel after every
// grant; defining FIB_SCHED_FIXED_PRIO_EN makes channel 0 always win.
module fib_rr_arb
    import fib_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef FIB_SCHED_FIXED_PRIO_EN
    // No pointer in fixed priority; clock and reset are kept for a uniform port list.
    wire unused_clk_reset = &{1'b0, clk, reset};

    // Channel 0 wins whenever it requests.
    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`else
    logic ptr;  // 0: channel 0 wins a tie, 1: channel 1 wins a tie

    // Single requester always wins; a tie is resolved by the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After each grant the pointer favours the channel that did not win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr <= grant[0];
        end
    end
`endif

endmodule

// File: rtl/fib_sched.sv
// fib_sched: two Fibonacci accumulator channels (x <= x + y, y <= x) that
// share one W-bit adder. Each channel runs IDLE -> RUN -> DONE: start loads
// SEED, granted steps add until x >= LIMIT, then the result is held until
// clr. ovf is a sticky record of any carry out of the adder.
// Optional build macro: FIB_SCHED_FIXED_PRIO_EN (fixed-priority arbiter).
module fib_sched
    import fib_sched_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LIMIT = DEF_LIMIT,
    parameter int SEED  = DEF_SEED
) (
    input  logic       clk,
    input  logic       reset,
    fib_sched_if.slave bus
);

    localparam logic [W-1:0] LIM_V  = W'(LIMIT);
    localparam logic [W-1:0] SEED_V = W'(SEED);

    state_t [1:0]        st;
    logic   [1:0][W-1:0] x;
    logic   [1:0][W-1:0] y;
    logic   [1:0]        busy;
    logic   [1:0]        done;
    logic                ovf;

    logic   [1:0]        start;
    logic   [1:0]        clr;
    logic   [1:0]        grant;
    logic                sel;
    logic   [W-1:0]      add_a;
    logic   [W-1:0]      add_b;
    logic   [W:0]        sum;
    logic                at_limit;

    assign start = {bus.start1, bus.start0};
    assign clr   = {bus.clr1, bus.clr0};

    // busy mirrors RUN exactly, so it doubles as the request vector.
    fib_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (busy),
        .grant (grant)
    );

    // The shared adder takes its operands from whichever channel is granted.
    assign sel      = grant[1];
    assign add_a    = x[sel];
    assign add_b    = y[sel];
    assign sum      = {1'b0, add_a} + {1'b0, add_b};
    assign at_limit = (add_a >= LIM_V);

    // Both channel FSMs plus the sticky carry flag; busy/done are registered with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= {IDLE, IDLE};
            x    <= '0;
            y    <= '0;
            busy <= '0;
            done <= '0;
            ovf  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    IDLE: begin
                        if (start[i]) begin
                            st[i]   <= RUN;
                            busy[i] <= 1'b1;
                            x[i]    <= SEED_V;
                            y[i]    <= SEED_V;
                        end
                    end
                    RUN: begin
                        if (grant[i]) begin
                            if (at_limit) begin
                                st[i]   <= DONE;
                                busy[i] <= 1'b0;
                                done[i] <= 1'b1;
                            end else begin
                                x[i] <= sum[W-1:0];
                                y[i] <= add_a;
                            end
                        end
                    end
                    DONE: begin
                        // clr has priority; a simultaneous start is simply not seen.
                        if (clr[i]) begin
                            st[i]   <= IDLE;
                            done[i] <= 1'b0;
                        end
                    end
                    default: begin
                        st[i]   <= IDLE;
                        busy[i] <= 1'b0;
                        done[i] <= 1'b0;
                    end
                endcase
            end
            if ((grant != 2'b00) && !at_limit && sum[W]) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.busy0 = busy[0];
    assign bus.busy1 = busy[1];
    assign bus.done0 = done[0];
    assign bus.done1 = done[1];
    assign bus.x0    = x[0];
    assign bus.x1    = x[1];
    assign bus.grant = grant;
    assign bus.ovf   = ovf;

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: scoreboard bench for fib_sched. Every accepted start pushes
// the run's expected result (from a plain-arithmetic Fibonacci model) into a
// per-channel queue; a monitor pops and checks it when done rises. Directed
// sequences cover reset, exact latency, arbitration order, overflow,
// asynchronous abort and clr/start priority; a random phase follows.
`timescale 1ns/1ps
module tb_fib_sched;

    localparam int W     = 8;
    localparam int LIM_A = 100;
    localparam int LIM_B = 255;
    localparam int SEED  = 1;
`ifdef FIB_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam int LAT_MUL = FIXED ? 20 : 2;

    typedef struct {
        int xf;
        int adds;
        int t0;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   stop_mon = 1'b0;
    bit   ovf_m = 1'b0;
    int   started [2];
    int   cleared [2];
    int   done_cnt [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fib_sched_if #(.W(W)) ifa ();
    fib_sched_if #(.W(W)) ifb ();

    fib_sched #(.W(W), .LIMIT(LIM_A), .SEED(SEED)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    fib_sched #(.W(W), .LIMIT(LIM_B), .SEED(SEED)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Fibonacci run from SEED until x >= lim (bounded), modulo 2^W.
    function automatic void fib_model(input int lim, output int xf, output int adds,
                                      output bit ov, output bit term);
        int xv, yv, s;
        xv = SEED; yv = SEED; adds = 0; ov = 1'b0;
        while (xv < lim && adds < 1000) begin
            s = xv + yv;
            if (s >= (1 << W)) ov = 1'b1;
            yv = xv;
            xv = s % (1 << W);
            adds++;
        end
        xf = xv;
        term = (xv >= lim);
    endfunction

    task automatic push(input int ch);
        exp_t e;
        int xf, adds;
        bit ov, term;
        fib_model(LIM_A, xf, adds, ov, term);
        e.xf = xf; e.adds = adds; e.t0 = cyc + 1;
        ovf_m = ovf_m | ov;
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Drive one cycle of requests on dut_a, keeping the bench's view of each channel.
    task automatic step(input bit s0, input bit s1, input bit c0, input bit c1);
        bit s [2];
        bit c [2];
        bit cd [2];
        bit idle, dn;
        s[0] = s0; s[1] = s1; c[0] = c0; c[1] = c1;
        for (int ch = 0; ch < 2; ch++) begin
            idle = (started[ch] == cleared[ch]);
            dn   = !idle && (done_cnt[ch] == started[ch]);
            cd[ch] = c[ch] && (idle || dn);
            if (cd[ch] && dn) begin
                cleared[ch]++;
            end else if (s[ch] && idle) begin
                push(ch);
                started[ch]++;
            end
        end
        ifa.start0 = s0; ifa.start1 = s1; ifa.clr0 = cd[0]; ifa.clr1 = cd[1];
        @(posedge clk); #1;
        ifa.start0 = 1'b0; ifa.start1 = 1'b0; ifa.clr0 = 1'b0; ifa.clr1 = 1'b0;
    endtask

    task automatic step_b(input bit s0, input bit c0);
        ifb.start0 = s0; ifb.clr0 = c0;
        @(posedge clk); #1;
        ifb.start0 = 1'b0; ifb.clr0 = 1'b0;
    endtask

    task automatic clear_model();
        started[0] = 0; started[1] = 0;
        cleared[0] = 0; cleared[1] = 0;
        q0.delete(); q1.delete();
        ovf_m = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ifa.start0 = 1'b0; ifa.start1 = 1'b0; ifa.clr0 = 1'b0; ifa.clr1 = 1'b0;
        ifb.start0 = 1'b0; ifb.start1 = 1'b0; ifb.clr0 = 1'b0; ifb.clr1 = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until_done0(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (ifa.done0) break;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk(nm, ifa.done0, 1);
    endtask

    task automatic clr0_until_idle(input string nm);
        for (int i = 0; i < 5; i++) begin
            if (!ifa.done0) break;
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk(nm, ifa.done0, 0);
    endtask

    initial begin
        fork
            // Monitor: invariants every cycle, scoreboard pop on each done rise.
            begin
                bit   pd [2];
                int   hold [2];
                bit   d;
                int   xv, lat;
                exp_t e;
                pd[0] = 1'b0; pd[1] = 1'b0;
                hold[0] = 0; hold[1] = 0;
                while (!stop_mon) begin
                    @(negedge clk);
                    if (!reset) begin
                        done_cnt[0] = 0; done_cnt[1] = 0;
                        pd[0] = 1'b0; pd[1] = 1'b0;
                    end else begin
                        chk("grant_not_both", (ifa.grant == 2'b11), 0);
                        chk("grant_outside_run", ifa.grant & ~{ifa.busy1, ifa.busy0}, 0);
                        chk("grant_missing", ((ifa.busy0 | ifa.busy1) && ifa.grant == 2'b00), 0);
                        chk("busy_and_done", {ifa.busy1 & ifa.done1, ifa.busy0 & ifa.done0}, 0);
                        for (int ch = 0; ch < 2; ch++) begin
                            d  = (ch == 0) ? ifa.done0 : ifa.done1;
                            xv = (ch == 0) ? int'(ifa.x0) : int'(ifa.x1);
                            if (d && !pd[ch]) begin
                                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                                    n_vec++; n_err++;
                                    $display("FAIL unexpected_done ch%0d: got done with no run pending, required none at %0t", ch, $time);
                                end else begin
                                    if (ch == 0) e = q0.pop_front(); else e = q1.pop_front();
                                    chk($sformatf("result_x ch%0d", ch), xv, e.xf);
                                    chk($sformatf("ovf_at_done ch%0d", ch), ifa.ovf, ovf_m);
                                    lat = cyc - e.t0;
                                    chk_rng($sformatf("done_latency ch%0d", ch), lat, e.adds + 1, LAT_MUL * (e.adds + 1));
                                    hold[ch] = e.xf;
                                end
                                done_cnt[ch]++;
                            end else if (d) begin
                                chk($sformatf("x_held ch%0d", ch), xv, hold[ch]);
                            end
                            pd[ch] = d;
                        end
                    end
                end
            end
            // Stimulus
            begin
                int xm, ym, s, rem0, rem1, turn, g, ovm;
                int xf, adds;
                bit ov, term;

                // Reset state, then idle with no start.
                do_reset();
                reset = 1'b0;
                #1;
                chk("reset_outputs", {ifa.grant, ifa.busy1, ifa.busy0, ifa.done1, ifa.done0, ifa.x1, ifa.x0, ifa.ovf}, 0);
                do_reset();
                for (int i = 0; i < 6; i++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk("idle_outputs", {ifa.grant, ifa.busy1, ifa.busy0, ifa.done1, ifa.done0, ifa.x1, ifa.x0, ifa.ovf}, 0);
                end

                // Single channel 0 run: exact trajectory and latency.
                step(1'b1, 1'b0, 1'b0, 1'b0);
                chk("single_busy0", ifa.busy0, 1);
                chk("single_x0_seed", ifa.x0, SEED);
                xm = SEED; ym = SEED;
                for (int k = 1; k <= 10; k++) begin
                    chk("single_grant", ifa.grant, 2'b01);
                    s = xm + ym; ym = xm; xm = s % 256;
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk($sformatf("single_x0 step%0d", k), ifa.x0, xm);
                    chk("single_not_done", ifa.done0, 0);
                end
                chk("single_grant_last", ifa.grant, 2'b01);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("single_done0", {ifa.done0, ifa.busy0, ifa.grant}, {1'b1, 1'b0, 2'b00});
                chk("single_x0_final", ifa.x0, 144);
                chk("single_ovf", ifa.ovf, 0);
                chk("single_x1_untouched", ifa.x1, 0);
                clr0_until_idle("single_clr0");
                chk("single_x0_kept", ifa.x0, 144);

                // Both channels started on the same edge.
                do_reset();
                step(1'b1, 1'b1, 1'b0, 1'b0);
                rem0 = 11; rem1 = 11; turn = 0;
                for (int k = 1; k <= 22; k++) begin
                    g = 0;
                    if (rem0 > 0 && rem1 > 0) g = FIXED ? 1 : (turn == 0 ? 1 : 2);
                    else if (rem0 > 0) g = 1;
                    else if (rem1 > 0) g = 2;
                    chk($sformatf("dual_grant k%0d", k), ifa.grant, g);
                    if (g == 1) begin rem0--; turn = 1; end
                    if (g == 2) begin rem1--; turn = 0; end
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk($sformatf("dual_done k%0d", k), {ifa.done1, ifa.done0}, {rem1 == 0, rem0 == 0});
                end
                chk("dual_x", {ifa.x1, ifa.x0}, {8'd144, 8'd144});
                step(1'b0, 1'b0, 1'b1, 1'b1);
                step(1'b0, 1'b0, 1'b1, 1'b1);
                chk("dual_cleared", {ifa.done1, ifa.done0}, 0);

                // Overflow on the LIMIT=255 instance.
                do_reset();
                step_b(1'b1, 1'b0);
                chk("ovf_seed", ifb.x0, SEED);
                xm = SEED; ym = SEED; ovm = 0;
                for (int k = 1; k <= 12; k++) begin
                    s = xm + ym;
                    if (s >= 256) ovm = 1;
                    ym = xm; xm = s % 256;
                    step_b(1'b0, 1'b0);
                    chk($sformatf("ovf_x0 step%0d", k), ifb.x0, xm);
                    chk($sformatf("ovf_flag step%0d", k), ifb.ovf, ovm);
                end
                chk("ovf_wrap_121", ifb.x0, 121);
                fib_model(LIM_B, xf, adds, ov, term);
                if (term) begin
                    for (int k = 13; k <= adds + 1; k++) step_b(1'b0, 1'b0);
                    chk("ovf_done0", {ifb.done0, ifb.busy0}, 2'b10);
                    chk("ovf_x_final", ifb.x0, xf);
                    chk("ovf_sticky_done", ifb.ovf, 1);
                    step_b(1'b0, 1'b1);
                    chk("ovf_clr_done0", ifb.done0, 0);
                    chk("ovf_sticky_clr", ifb.ovf, 1);
                end else begin
                    repeat (40) step_b(1'b0, 1'b0);
                    chk("ovf_still_busy", ifb.busy0, 1);
                    chk("ovf_sticky_run", ifb.ovf, 1);
                end

                // Asynchronous reset in the middle of a run.
                do_reset();
                step(1'b1, 1'b0, 1'b0, 1'b0);
                for (int k = 1; k <= 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("abort_x0_21", ifa.x0, 21);
                #2 reset = 1'b0;
                #1;
                chk("abort_async_outputs", {ifa.grant, ifa.busy1, ifa.busy0, ifa.done1, ifa.done0, ifa.x1, ifa.x0, ifa.ovf}, 0);
                clear_model();
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                step(1'b1, 1'b0, 1'b0, 1'b0);
                chk("restart_seed", {ifa.busy0, ifa.x0}, {1'b1, 8'(SEED)});
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("restart_x2", ifa.x0, 2);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("restart_x3", ifa.x0, 3);
                run_until_done0("restart_done0");
                clr0_until_idle("restart_clr0");

                // clr and start together in DONE: clr wins, start seen next cycle.
                step(1'b1, 1'b0, 1'b0, 1'b0);
                run_until_done0("prio_done0");
                step(1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b1, 1'b0);
                chk("prio_to_idle", {ifa.done0, ifa.busy0}, 2'b00);
                step(1'b1, 1'b0, 1'b0, 1'b0);
                chk("prio_restart", {ifa.busy0, ifa.x0}, {1'b1, 8'(SEED)});
                run_until_done0("prio_done0_again");
                clr0_until_idle("prio_clr0");

                // Random start/clr traffic on both channels.
                do_reset();
                for (int i = 0; i < 600; i++) begin
                    step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                         $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
                end
                for (int i = 0; i < 300; i++) begin
                    if (started[0] == cleared[0] && started[1] == cleared[1]) break;
                    step(1'b0, 1'b0, 1'b1, 1'b1);
                end
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("rand_q0_drained", q0.size(), 0);
                chk("rand_q1_drained", q1.size(), 0);
                chk("rand_idle_at_end", {ifa.busy1, ifa.busy0, ifa.done1, ifa.done0, ifa.grant}, 0);
                chk("rand_ovf", ifa.ovf, ovf_m);
                stop_mon = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Schedules two independent Fibonacci-style accumulator channels onto one shared W-bit adder.
- Per step, a channel updates x <= x + y and y <= x.
- Each channel is started by its requester, iterates until x >= LIMIT, then reports done and holds its result until cleared.
- A 2-way arbiter grants the adder to at most one running channel per cycle.
- Intended as a formal-verification target in the SoCV basic design set.

Parameters:
- W, 8, datapath width of x, y and the adder.
- LIMIT, 100, termination threshold; a channel stops when its granted x >= LIMIT.
- SEED, 1, initial value loaded into both x and y on start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start0  input  1  start request, channel 0.
- start1  input  1  start request, channel 1.
- clr0  input  1  acknowledge/clear of done, channel 0.
- clr1  input  1  acknowledge/clear of done, channel 1.
- busy0  output  1  channel 0 in RUN.
- busy1  output  1  channel 1 in RUN.
- done0  output  1  channel 0 in DONE.
- done1  output  1  channel 1 in DONE.
- x0  output  W  channel 0 accumulator x.
- x1  output  W  channel 1 accumulator x.
- grant  output  2  one-hot adder grant this cycle (bit i = channel i); combinational from state and arbiter pointer.
- ovf  output  1  sticky: some adder step produced a carry out of bit W-1.

Behaviour:
- Reset (reset == 0, asynchronous):
  - Both channels go to IDLE; x, y = 0; busy, done, ovf = 0.
  - Arbiter pointer favours channel 0.
  - Reset asserted mid-run aborts immediately; no partial state survives.
- Per-channel FSM, IDLE/RUN/DONE:
  - IDLE: start sampled high at an edge -> RUN, with x <= SEED and y <= SEED. start is ignored in RUN and DONE.
  - RUN, granted, x < LIMIT: x <= (x + y) mod 2^W; y <= x; ovf <= 1 if the carry is set. Stay in RUN.
  - RUN, granted, x >= LIMIT: -> DONE; x and y unchanged; no add performed.
  - RUN, not granted: hold all state.
  - DONE: done = 1 and x is held until clr is sampled high -> IDLE (x, y retained). If clr and start are both high in DONE, clr wins; start is not re-sampled until the next cycle in IDLE.
- Arbiter:
  - grant is all zero when no channel is in RUN.
  - With one channel in RUN, that channel is granted every cycle.
  - With both in RUN, round-robin: the pointer toggles to the other channel after each grant.
  - grant is never 2'b11.
- Latency, single channel, SEED=1, LIMIT=100:
  - Start sampled at edge N.
  - 10 adds at edges N+1..N+10 (x: 2,3,5,8,13,21,34,55,89,144).
  - Terminating grant at edge N+11; done = 1 after edge N+11.
- ovf is sticky and is cleared only by reset.

Optional Feature:
- Macro: FIB_SCHED_FIXED_PRIO_EN.
- Defined: the arbiter is fixed-priority; channel 0 always wins when both are in RUN, and the pointer is removed.
- Undefined: round-robin as specified above.
- Either way: one-hot grant, and no grant to a channel outside RUN.

Decomposition:
- Package fib_sched_pkg:
  - state typedef (IDLE, RUN, DONE);
  - default constants for W, LIMIT, SEED.
- Sub-module fib_rr_arb:
  - 2-request arbiter with pointer register on clk/reset;
  - the FIB_SCHED_FIXED_PRIO_EN switch lives inside it.
- Datapath and FSMs stay in fib_sched.

Test Plan:
- Reset release, no start -> grant = 00, busy/done = 0, x0 = x1 = 0, ovf = 0 indefinitely.
- start0 pulse at edge N, defaults -> grant = 01 every cycle; x0 reaches 144 after edge N+10; done0 = 1 after edge N+11; ovf = 0.
- start0 and start1 at the same edge N, round-robin -> grant alternates 01, 10, ...
  - ch0 adds at odd offsets, ch1 at even offsets;
  - done0 after edge N+21, done1 after edge N+22; both x = 144.
- Same stimulus with FIB_SCHED_FIXED_PRIO_EN -> ch0 granted at N+1..N+11 (done0 after N+11), then ch1 granted at N+12..N+22 (done1 after N+22).
- LIMIT = 255, start0 -> step from x = 233, y = 144 gives x0 = 121 and ovf = 1; ovf stays 1 through done0 and clr0.
- reset pulled low mid-RUN while x0 = 21 -> all outputs 0 asynchronously; after release and a new start0, the sequence restarts from SEED.
- In DONE, clr0 and start0 high together -> IDLE next cycle with done0 = 0 and busy0 = 0; a start0 the following cycle -> RUN.
